// File: rtl/csr_pkg.sv
// csr_pkg: shared machine-mode CSR types, trap sequencer enums and interrupt constants
package csr_pkg;
  localparam int XLEN = 64;
  localparam logic [1:0] MODE_M = 2'b11;
  localparam logic [1:0] MODE_U = 2'b00;
  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;
  localparam int MCAUSE_IRQ_BIT = 63;
  typedef struct packed {
    logic [50:0] hi;
    logic [1:0]  mpp;
    logic [2:0]  rsv2;
    logic        mpie;
    logic [2:0]  rsv1;
    logic        mie;
    logic [2:0]  rsv0;
  } mstatus_t;
  typedef enum logic [1:0] {TK_NONE, TK_EXC, TK_IRQ, TK_MRET} trap_kind_t;
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIRECT} trap_state_t;
endpackage

// File: rtl/csr_irq_arbiter.sv
// csr_irq_arbiter: interrupt eligibility and fixed-priority cause encoding (MEI > MSI > MTI)
module csr_irq_arbiter
  import csr_pkg::*;
(
  input  logic [XLEN-1:0] i_mip,
  input  logic [XLEN-1:0] i_mie,
  input  mstatus_t        i_mstatus,
  input  logic [1:0]      i_mode,
  output logic            o_irq_valid,
  output logic [3:0]      o_irq_code
);
  logic [XLEN-1:0] w_pend;
  logic            w_en;
  logic            w_unused_bits;
  always_comb begin
    w_pend        = i_mip & i_mie;
    w_en          = (i_mode != MODE_M) | i_mstatus.mie;
    o_irq_valid   = w_en & (w_pend[IRQ_MEI] | w_pend[IRQ_MSI] | w_pend[IRQ_MTI]);
    o_irq_code    = w_pend[IRQ_MEI] ? 4'(IRQ_MEI) : w_pend[IRQ_MSI] ? 4'(IRQ_MSI) : 4'(IRQ_MTI);
    w_unused_bits = |{w_pend[63:12], w_pend[10:8], w_pend[6:4], w_pend[2:0],
                      i_mstatus.hi, i_mstatus.mpp, i_mstatus.rsv2, i_mstatus.mpie,
                      i_mstatus.rsv1, i_mstatus.rsv0};
  end
endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: commit-stage trap/mret sequencer driving an atomic CSR update and fetch redirect
module csr_trap_ctrl
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] cur_mstatus,
  input  logic [XLEN-1:0] cur_mtvec,
  input  logic [XLEN-1:0] cur_mepc,
  input  logic [XLEN-1:0] cur_mie,
  input  logic [XLEN-1:0] cur_mip,
  input  logic [1:0]      cur_mode,
  input  logic            mem_busy,
  output logic            stall,
  output logic            flush,
  output logic            trap_we,
  output logic [XLEN-1:0] trap_mepc,
  output logic [XLEN-1:0] trap_mcause,
  output logic [XLEN-1:0] trap_mtval,
  output logic [XLEN-1:0] trap_mstatus,
  output logic [1:0]      trap_mode,
  output logic            trap_is_mret,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);
  trap_state_t     r_state;
  trap_kind_t      r_kind;
  logic [3:0]      r_code;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_pc;
  logic            w_irq_valid;
  logic [3:0]      w_irq_code;
  logic            w_mret;
  mstatus_t        w_ms;
  mstatus_t        w_trap_ms;
  mstatus_t        w_mret_ms;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_target;
  csr_irq_arbiter u_arb (
    .i_mip      (cur_mip),
    .i_mie      (cur_mie),
    .i_mstatus  (mstatus_t'(cur_mstatus)),
    .i_mode     (cur_mode),
    .o_irq_valid(w_irq_valid),
    .o_irq_code (w_irq_code)
  );
  always_comb begin
    w_mret         = r_kind == TK_MRET;
    w_ms           = mstatus_t'(cur_mstatus);
    w_trap_ms      = w_ms;
    w_trap_ms.mpie = w_ms.mie;
    w_trap_ms.mie  = 1'b0;
    w_trap_ms.mpp  = cur_mode;
    w_mret_ms      = w_ms;
    w_mret_ms.mie  = w_ms.mpie;
    w_mret_ms.mpie = 1'b1;
    w_mret_ms.mpp  = MODE_U;
    w_base         = cur_mtvec & ~64'd3;
    w_target       = w_mret ? cur_mepc
                   : (r_kind == TK_IRQ && cur_mtvec[1:0] == 2'b01) ? w_base + {58'd0, r_code, 2'b00}
                   : w_base;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_kind         <= TK_NONE;
      r_code         <= '0;
      r_tval         <= '0;
      r_pc           <= '0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      trap_we        <= 1'b0;
      trap_mepc      <= '0;
      trap_mcause    <= '0;
      trap_mtval     <= '0;
      trap_mstatus   <= '0;
      trap_mode      <= '0;
      trap_is_mret   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      trap_we <= 1'b0;
      case (r_state)
        S_IDLE: if (commit_valid && (exc_valid || mret_valid || w_irq_valid)) begin
          r_kind  <= exc_valid ? TK_EXC : mret_valid ? TK_MRET : TK_IRQ;
          r_code  <= exc_valid ? exc_code : w_irq_code;
          r_tval  <= exc_valid ? exc_tval : '0;
          r_pc    <= exc_valid ? commit_pc : next_pc;
          stall   <= 1'b1;
          flush   <= 1'b1;
          r_state <= S_DRAIN;
        end
        S_DRAIN: if (!mem_busy) begin
          trap_we      <= 1'b1;
          trap_is_mret <= w_mret;
          trap_mepc    <= w_mret ? '0 : r_pc & ~64'd3;
          trap_mcause  <= w_mret ? '0 : {r_kind == TK_IRQ, 59'd0, r_code};
          trap_mtval   <= w_mret ? '0 : r_tval;
          trap_mstatus <= w_mret ? w_mret_ms : w_trap_ms;
          trap_mode    <= w_mret ? w_ms.mpp : MODE_M;
          r_state      <= S_COMMIT;
        end
        S_COMMIT: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= w_target;
          r_state        <= S_REDIRECT;
        end
        S_REDIRECT: if (redirect_ready) begin
          redirect_valid <= 1'b0;
          stall          <= 1'b0;
          flush          <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end
endmodule
